pump_pwm_driver: RTL and testbench



---
 rtl/pump_pwm_pkg.sv | 36 +++
 rtl/pump_pwm_channel.sv | 124 ++++++++++++
 rtl/pump_pwm_driver.sv | 96 +++++++++
 tb/tb_pump_pwm_driver.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pump_pwm_pkg.sv
// Shared types and helpers for the pump PWM driver.
//   pwm_ch_state_t : per-channel control state (OFF / KICK / RAMP / HOLD)
//   PWM_TOP        : last value of the 8-bit PWM count (count runs 0..254)
//   ramp_toward()  : one slew-limited step from a current duty toward a target
package pump_pwm_pkg;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_KICK = 2'd1,
    CH_RAMP = 2'd2,
    CH_HOLD = 2'd3
  } pwm_ch_state_t;

  localparam logic [7:0] PWM_TOP = 8'd254;

  // Move cur toward tgt by at most step. The sums are taken in 9 bits so the
  // result can never overshoot tgt or wrap past 0/255.
  function automatic logic [7:0] ramp_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
    logic [8:0] up;
    logic [8:0] down;
    logic [7:0] res;
    up   = {1'b0, cur} + {1'b0, step};
    down = {1'b0, cur} - {1'b0, step};
    res  = cur;
    if (cur < tgt) begin
      res = (up >= {1'b0, tgt}) ? tgt : up[7:0];
    end else if (cur > tgt) begin
      // down[8] set means the subtraction went below zero
      res = (down[8] || (down[7:0] <= tgt)) ? tgt : down[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pump_pwm_channel.sv
// One pump PWM channel: start-up kick, slew-limited ramp, hold and compare.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_enable    : low forces the channel OFF with duty 0 and output low
//   i_boundary  : high on the clk that ends a PWM period (count 254 -> 0)
//   i_count     : shared 8-bit PWM count
//   i_target    : commanded duty, sampled only at a period boundary
//   o_pwm       : registered gate drive, (count < duty_eff) one clk late
//   o_settled   : high in OFF and HOLD
//   o_state     : current channel state (debug visibility)
module pump_pwm_channel
  import pump_pwm_pkg::*;
#(
  parameter logic [7:0] KICK_DUTY    = 8'd200,
  parameter int         KICK_PERIODS = 4,
  parameter logic [7:0] RAMP_STEP    = 8'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_enable,
  input  logic       i_boundary,
  input  logic [7:0] i_count,
  input  logic [7:0] i_target,
  output logic       o_pwm,
  output logic       o_settled,
  output logic [1:0] o_state
);

  // Kick counter is loaded with the number of remaining extra kick periods.
  localparam logic [7:0] KICK_LOAD = (KICK_PERIODS > 0) ? 8'(KICK_PERIODS - 1) : 8'd0;

  pwm_ch_state_t r_state;
  logic [7:0]    r_kick_cnt;
  logic [7:0]    r_duty_eff;
  logic          r_pwm;
  logic          r_settled;
  logic [7:0]    w_step;

  // One ramp step from the present duty. In OFF the duty is 0, so this is
  // min(target, RAMP_STEP); in KICK the duty is KICK_DUTY.
  assign w_step = ramp_toward(r_duty_eff, i_target, RAMP_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CH_OFF;
      r_kick_cnt <= 8'd0;
      r_duty_eff <= 8'd0;
      r_pwm      <= 1'b0;
      r_settled  <= 1'b1;
    end else if (!i_enable) begin
      r_state    <= CH_OFF;
      r_kick_cnt <= 8'd0;
      r_duty_eff <= 8'd0;
      r_pwm      <= 1'b0;
      r_settled  <= 1'b1;
    end else begin
      r_pwm <= (i_count < r_duty_eff);
      if (i_boundary) begin
        case (r_state)
          CH_OFF: begin
            if (i_target != 8'd0) begin
              if (KICK_PERIODS > 0) begin
                r_state    <= CH_KICK;
                r_duty_eff <= KICK_DUTY;
                r_kick_cnt <= KICK_LOAD;
              end else begin
                r_state    <= CH_RAMP;
                r_duty_eff <= w_step;
              end
              r_settled <= 1'b0;
            end
          end
          CH_KICK: begin
            if (i_target == 8'd0) begin
              r_state    <= CH_OFF;
              r_duty_eff <= 8'd0;
              r_settled  <= 1'b1;
            end else if (r_kick_cnt != 8'd0) begin
              r_kick_cnt <= r_kick_cnt - 8'd1;
            end else begin
              r_state    <= CH_RAMP;
              r_duty_eff <= w_step;
            end
          end
          CH_RAMP: begin
            if (i_target == 8'd0) begin
              // Stop is immediate; there is no ramp-down.
              r_state    <= CH_OFF;
              r_duty_eff <= 8'd0;
              r_settled  <= 1'b1;
            end else begin
              r_duty_eff <= w_step;
              if (w_step == i_target) begin
                r_state   <= CH_HOLD;
                r_settled <= 1'b1;
              end
            end
          end
          CH_HOLD: begin
            if (i_target == 8'd0) begin
              r_state    <= CH_OFF;
              r_duty_eff <= 8'd0;
            end else if (i_target != r_duty_eff) begin
              r_state    <= CH_RAMP;
              r_duty_eff <= w_step;
              r_settled  <= 1'b0;
            end
          end
          default: begin
            r_state    <= CH_OFF;
            r_duty_eff <= 8'd0;
            r_kick_cnt <= 8'd0;
            r_settled  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_pwm     = r_pwm;
  assign o_settled = r_settled;
  assign o_state   = r_state;

endmodule

// File: rtl/pump_pwm_driver.sv
// Dual-channel PWM output stage for the fill (A) and drain (B) pumps.
// Holds the prescaler, the shared 0..254 PWM count and the period marker;
// each pump has its own pump_pwm_channel.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   enable                 : global enable; low forces both pumps off
//   pwm_duty_a/b           : target duties (0 = off, 255 = always on)
//   pwm_out_a/b            : gate drives
//   settled_a/b            : effective duty has reached target (or channel off)
//   period_start           : one-clk pulse, high in the first clk of each period
//   dbg_state_a/b          : channel state (pwm_ch_state_t encoding)
module pump_pwm_driver
  import pump_pwm_pkg::*;
#(
  parameter int         PRESCALE     = 10,
  parameter logic [7:0] KICK_DUTY    = 8'd200,
  parameter int         KICK_PERIODS = 4,
  parameter logic [7:0] RAMP_STEP    = 8'd16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] pwm_duty_a,
  input  logic [7:0] pwm_duty_b,
  output logic       pwm_out_a,
  output logic       pwm_out_b,
  output logic       settled_a,
  output logic       settled_b,
  output logic       period_start,
  output logic [1:0] dbg_state_a,
  output logic [1:0] dbg_state_b
);

  // A prescale of 1 still needs a 1-bit counter (it simply stays at 0).
  localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_prescale;
  logic [7:0]      r_count;
  logic            r_period_start;
  logic            w_tick;
  logic            w_boundary;

  assign w_tick     = (r_prescale == PS_LAST);
  assign w_boundary = w_tick && (r_count == PWM_TOP);

  // The counter free-runs regardless of enable so period timing is stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale     <= '0;
      r_count        <= 8'd0;
      r_period_start <= 1'b0;
    end else begin
      r_prescale     <= w_tick ? '0 : r_prescale + 1'b1;
      r_period_start <= w_boundary;
      if (w_tick) begin
        r_count <= (r_count == PWM_TOP) ? 8'd0 : r_count + 8'd1;
      end
    end
  end

  assign period_start = r_period_start;

  pump_pwm_channel #(
    .KICK_DUTY    (KICK_DUTY),
    .KICK_PERIODS (KICK_PERIODS),
    .RAMP_STEP    (RAMP_STEP)
  ) u_ch_a (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_enable   (enable),
    .i_boundary (w_boundary),
    .i_count    (r_count),
    .i_target   (pwm_duty_a),
    .o_pwm      (pwm_out_a),
    .o_settled  (settled_a),
    .o_state    (dbg_state_a)
  );

  pump_pwm_channel #(
    .KICK_DUTY    (KICK_DUTY),
    .KICK_PERIODS (KICK_PERIODS),
    .RAMP_STEP    (RAMP_STEP)
  ) u_ch_b (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_enable   (enable),
    .i_boundary (w_boundary),
    .i_count    (r_count),
    .i_target   (pwm_duty_b),
    .o_pwm      (pwm_out_b),
    .o_settled  (settled_b),
    .o_state    (dbg_state_b)
  );

endmodule

// File: tb/tb_pump_pwm_driver.sv
module tb_pump_pwm_driver;
  import pump_pwm_pkg::*;

  localparam int         P      = 2;
  localparam logic [7:0] KD     = 8'd200;
  localparam int         KP     = 2;
  localparam logic [7:0] RS     = 8'd16;
  localparam int         PERIOD = 255 * P;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1;
  logic [7:0] duty_a = 8'd0;
  logic [7:0] duty_b = 8'd0;
  logic       pwm_out_a, pwm_out_b, settled_a, settled_b, period_start;
  logic [1:0] dbg_state_a, dbg_state_b;

  always #5 clk = ~clk;

  pump_pwm_driver #(
    .PRESCALE (P), .KICK_DUTY (KD), .KICK_PERIODS (KP), .RAMP_STEP (RS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .pwm_duty_a   (duty_a),
    .pwm_duty_b   (duty_b),
    .pwm_out_a    (pwm_out_a),
    .pwm_out_b    (pwm_out_b),
    .settled_a    (settled_a),
    .settled_b    (settled_b),
    .period_start (period_start),
    .dbg_state_a  (dbg_state_a),
    .dbg_state_b  (dbg_state_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Position inside the period is one integer; count = pos / P and the
  // boundary is the last clk of the period.
  int            m_pos = 0;
  int            m_pwm[2] = '{0, 0};
  int            m_ps = 0;
  pwm_ch_state_t m_st[2] = '{CH_OFF, CH_OFF};
  int            m_duty[2] = '{0, 0};
  int            m_kick[2] = '{0, 0};
  logic [7:0]    exp_q_a[$];   // duty in force for each period, channel A
  logic [7:0]    exp_q_b[$];

  function automatic int step_toward(input int cur, input int tgt);
    if (cur < tgt) return (cur + int'(RS) > tgt) ? tgt : cur + int'(RS);
    if (cur > tgt) return (cur - int'(RS) < tgt) ? tgt : cur - int'(RS);
    return cur;
  endfunction

  task automatic model_period(input int ch, input int tgt);
    case (m_st[ch])
      CH_OFF: if (tgt != 0) begin
        if (KP > 0) begin m_st[ch] = CH_KICK; m_duty[ch] = int'(KD); m_kick[ch] = KP - 1; end
        else begin m_st[ch] = CH_RAMP; m_duty[ch] = (tgt < int'(RS)) ? tgt : int'(RS); end
      end
      CH_KICK: if (tgt == 0) begin m_st[ch] = CH_OFF; m_duty[ch] = 0; end
               else if (m_kick[ch] > 0) m_kick[ch]--;
               else begin m_st[ch] = CH_RAMP; m_duty[ch] = step_toward(m_duty[ch], tgt); end
      CH_RAMP: if (tgt == 0) begin m_st[ch] = CH_OFF; m_duty[ch] = 0; end
               else begin
                 m_duty[ch] = step_toward(m_duty[ch], tgt);
                 if (m_duty[ch] == tgt) m_st[ch] = CH_HOLD;
               end
      default: if (tgt == 0) begin m_st[ch] = CH_OFF; m_duty[ch] = 0; end
               else if (tgt != m_duty[ch]) begin m_st[ch] = CH_RAMP; m_duty[ch] = step_toward(m_duty[ch], tgt); end
    endcase
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pos = 0; m_ps = 0;
      for (int c = 0; c < 2; c++) begin
        m_pwm[c] = 0; m_st[c] = CH_OFF; m_duty[c] = 0; m_kick[c] = 0;
      end
    end else begin
      m_ps = (m_pos == PERIOD - 1) ? 1 : 0;
      for (int c = 0; c < 2; c++) begin
        if (!enable) begin
          m_pwm[c] = 0; m_st[c] = CH_OFF; m_duty[c] = 0; m_kick[c] = 0;
        end else begin
          m_pwm[c] = ((m_pos / P) < m_duty[c]) ? 1 : 0;
          if (m_ps == 1) begin
            model_period(c, (c == 0) ? int'(duty_a) : int'(duty_b));
            if (c == 0) exp_q_a.push_back(8'(m_duty[0]));
            else        exp_q_b.push_back(8'(m_duty[1]));
          end
        end
      end
      m_pos = (m_pos + 1) % PERIOD;
    end
  end

  // ---------------- per-cycle compare ----------------
  function automatic int settled_of(input pwm_ch_state_t s);
    return (s == CH_OFF || s == CH_HOLD) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("pwm_a", int'(pwm_out_a), m_pwm[0]);
      check("pwm_b", int'(pwm_out_b), m_pwm[1]);
      check("settled_a", int'(settled_a), settled_of(m_st[0]));
      check("settled_b", int'(settled_b), settled_of(m_st[1]));
      check("period_start", int'(period_start), m_ps);
      check("state_a", int'(dbg_state_a), int'(m_st[0]));
      check("state_b", int'(dbg_state_b), int'(m_st[1]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ps();
    int t = 0;
    do begin @(negedge clk); t++; end while (!period_start && t < PERIOD + 10);
    if (!period_start) check("ps_timeout", 0, 1);
  endtask

  task automatic wait_hist(input int ch, input int n);
    int t = 0;
    while (((ch == 0) ? exp_q_a.size() : exp_q_b.size()) < n && t < (n + 2) * PERIOD) begin
      @(negedge clk); t++;
    end
    check("hist_timeout", (ch == 0) ? exp_q_a.size() : exp_q_b.size(), n);
  endtask

  // Counts high clks of one full period, starting after a period_start.
  task automatic measure(input int ch, output int highs);
    highs = 0;
    wait_ps();
    repeat (PERIOD) begin
      @(negedge clk);
      highs += (ch == 0) ? int'(pwm_out_a) : int'(pwm_out_b);
    end
  endtask

  task automatic first_ps_after_release();
    int n = 0;
    @(negedge clk); #2 reset_n = 1'b1;
    do begin @(negedge clk); n++; end while (!period_start && n < PERIOD + 10);
    check("first_ps_clk", n, PERIOD);
  endtask

  // ---------------- stimulus ----------------
  int highs;
  int mn;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk_on = 1'b1;
    check("rst_pwm_a", int'(pwm_out_a), 0);
    check("rst_settled_a", int'(settled_a), 1);
    check("rst_settled_b", int'(settled_b), 1);
    check("rst_ps", int'(period_start), 0);
    first_ps_after_release();

    // Start-up kick then ramp to 230.
    duty_a = 8'd230; exp_q_a.delete();
    wait_hist(0, 4);
    check("a_p1", int'(exp_q_a[0]), 200);
    check("a_p2", int'(exp_q_a[1]), 200);
    check("a_p3", int'(exp_q_a[2]), 216);
    check("a_p4", int'(exp_q_a[3]), 230);
    measure(0, highs);
    check("a_highs_230", highs, 230 * P);
    check("a_settled_hold", int'(settled_a), 1);

    // Kick above target then ramp down to 77; then stop.
    duty_b = 8'd77; exp_q_b.delete();
    wait_hist(1, 10);
    check("b_p3", int'(exp_q_b[2]), 184);
    check("b_p9", int'(exp_q_b[8]), 88);
    check("b_p10", int'(exp_q_b[9]), 77);
    @(negedge clk);
    check("b_settled", int'(settled_b), 1);
    duty_b = 8'd0;
    measure(1, highs);
    check("b_off_highs", highs, 0);

    // Mid-period change in HOLD does not disturb the running period.
    wait_ps();
    repeat (50) @(negedge clk);
    duty_a = 8'd100; exp_q_a.delete();
    highs = 0;
    repeat (PERIOD - 50) begin @(negedge clk); highs += int'(pwm_out_a); end
    check("a_midperiod_highs", highs, 230 * P - 50);
    wait_hist(0, 9);
    check("a_down_p1", int'(exp_q_a[0]), 214);
    check("a_down_p8", int'(exp_q_a[7]), 102);
    check("a_down_p9", int'(exp_q_a[8]), 100);
    mn = 255;
    foreach (exp_q_a[i]) if (int'(exp_q_a[i]) < mn) mn = int'(exp_q_a[i]);
    check("a_no_undershoot", mn, 100);

    // Full-on and full-off extremes.
    duty_a = 8'd255; exp_q_a.delete();
    wait_hist(0, 10);
    check("a_up_p10", int'(exp_q_a[9]), 255);
    measure(0, highs);
    check("a_highs_255", highs, PERIOD);
    duty_a = 8'd0;
    measure(0, highs);
    check("a_highs_0", highs, 0);

    // Enable drop while both ramp, then restart.
    duty_a = 8'd230; duty_b = 8'd180; exp_q_a.delete(); exp_q_b.delete();
    wait_hist(0, 3);
    check("b_ramp_p3", int'(exp_q_b[2]), 184);
    check("a_ramp_settled", int'(settled_a), 0);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_pwm_a", int'(pwm_out_a), 0);
    check("dis_pwm_b", int'(pwm_out_b), 0);
    check("dis_settled_a", int'(settled_a), 1);
    check("dis_settled_b", int'(settled_b), 1);
    repeat (PERIOD + 37) @(negedge clk);
    enable = 1'b1; exp_q_a.delete();
    wait_hist(0, 1);
    check("reen_kick", int'(exp_q_a[0]), 200);

    // Random duties, mid-period changes and enable toggles.
    for (int it = 0; it < 30; it++) begin
      int r;
      repeat ($urandom_range(1, PERIOD)) @(negedge clk);
      r = $urandom_range(0, 9);
      if (r == 0) duty_a = 8'd0;
      else if (r == 1) duty_a = 8'd255;
      else duty_a = 8'($urandom_range(1, 254));
      if ($urandom_range(0, 1) == 1) duty_b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) enable = ~enable;
    end
    enable = 1'b1;
    repeat (2 * PERIOD) @(negedge clk);

    // Reset in the middle of operation.
    duty_a = 8'd230;
    repeat (3 * PERIOD + 111) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_pwm_a", int'(pwm_out_a), 0);
    check("mid_rst_pwm_b", int'(pwm_out_b), 0);
    check("mid_rst_settled_a", int'(settled_a), 1);
    check("mid_rst_ps", int'(period_start), 0);
    repeat (3) @(negedge clk);
    first_ps_after_release();
    repeat (PERIOD) @(negedge clk);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
